// File: rtl/crack_scheduler.sv
// Crack scheduler: copies the ciphertext from global memory into the engines' local
// memories, starts NENG striped engines, and picks the lowest-index winner.
module crack_scheduler #(
   parameter  int NENG = 4,
   localparam int W    = $clog2(NENG)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   output logic               rdy,
   output logic [23:0]        key,
   output logic               key_valid,
   output logic [7:0]         ct_addr,
   input  logic [7:0]         ct_rddata,
   output logic [7:0]         loc_addr,
   output logic [7:0]         loc_wrdata,
   output logic               loc_wren,
   output logic               loc_sel,
   output logic [NENG-1:0]    eng_en,
   input  logic [NENG-1:0]    eng_rdy,
   input  logic [NENG-1:0]    eng_key_valid,
   input  logic [24*NENG-1:0] eng_key,
   output logic [24*NENG-1:0] eng_base,
   output logic [NENG-1:0]    eng_abort,
   output logic [NENG-1:0]    eng_pt_en,
   output logic [W-1:0]       pt_sel
);

   typedef enum logic [3:0] {IDLE, LEN, COPY, START, BLANK, RUN, PT, PTWAIT, DONE} state_t;

   state_t                  state;
   logic [1:0]              ph;
   logic [8:0]              cnt;
   logic [7:0]              len;
   logic [NENG-1:0][23:0]   keys;
   logic [NENG-1:0]         hit;
   logic                    win_any;
   logic [W-1:0]            win_idx;

   for (genvar k = 0; k < NENG; k++) begin : g_lane
      assign keys[k]             = eng_key[24*k +: 24];
      assign eng_base[24*k +: 24] = 24'(k);
   end

   assign hit = eng_key_valid & eng_rdy;

   // Scan downward so the lowest-index hit wins.
   always_comb begin
      win_any = 1'b0;
      win_idx = '0;
      for (int k = NENG-1; k >= 0; k--) begin
         if (hit[k]) begin
            win_any = 1'b1;
            win_idx = W'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         ph         <= '0;
         cnt        <= '0;
         len        <= '0;
         rdy        <= 1'b1;
         key        <= '0;
         key_valid  <= 1'b0;
         pt_sel     <= '0;
         ct_addr    <= '0;
         loc_addr   <= '0;
         loc_wrdata <= '0;
         loc_wren   <= 1'b0;
         loc_sel    <= 1'b1;
         eng_en     <= '0;
         eng_abort  <= '0;
         eng_pt_en  <= '0;
      end else begin
         loc_wren <= 1'b0;
         case (state)
            IDLE, DONE: if (en) begin
               state     <= LEN;
               rdy       <= 1'b0;
               key_valid <= 1'b0;
               key       <= '0;
               pt_sel    <= '0;
               ct_addr   <= '0;
               loc_sel   <= 1'b1;
               ph        <= '0;
            end
            // Each global read takes three cycles: present, pipeline, sample.
            LEN: if (ph == 2'd2) begin
               len        <= ct_rddata;
               loc_addr   <= '0;
               loc_wrdata <= ct_rddata;
               loc_wren   <= 1'b1;
               ph         <= '0;
               cnt        <= 9'd1;
               ct_addr    <= 8'd1;
               state      <= (ct_rddata == 8'd0) ? START : COPY;
            end else ph <= ph + 2'd1;
            COPY: if (ph == 2'd2) begin
               loc_addr   <= cnt[7:0];
               loc_wrdata <= ct_rddata;
               loc_wren   <= 1'b1;
               ph         <= '0;
               if (cnt == {1'b0, len}) state <= START;
               else begin
                  cnt     <= cnt + 9'd1;
                  ct_addr <= ct_addr + 8'd1;
               end
            end else ph <= ph + 2'd1;
            // Pulse is issued and retired while still in START.
            START: if (ph == 2'd0) begin
               if (&eng_rdy) begin
                  eng_en  <= '1;
                  loc_sel <= 1'b0;
                  ph      <= 2'd1;
               end
            end else begin
               eng_en <= '0;
               ph     <= '0;
               state  <= BLANK;
            end
            BLANK: if (ph == 2'd1) begin
               ph    <= '0;
               state <= RUN;
            end else ph <= ph + 2'd1;
            RUN: if (ph == 2'd0) begin
               if (win_any) begin
                  key       <= keys[win_idx];
                  pt_sel    <= win_idx;
                  eng_abort <= ~(NENG'(1) << win_idx);
                  ph        <= 2'd1;
               end else if (&eng_rdy) begin
                  state     <= DONE;
                  rdy       <= 1'b1;
                  key_valid <= 1'b0;
                  key       <= '0;
               end
            end else begin
               eng_abort <= '0;
               ph        <= '0;
               state     <= PT;
            end
            PT: begin
               case (ph)
                  2'd0:    eng_pt_en <= NENG'(1) << pt_sel;
                  2'd1:    eng_pt_en <= '0;
                  default: ;
               endcase
               ph <= ph + 2'd1;
               if (ph == 2'd3) state <= PTWAIT;
            end
            PTWAIT: if (eng_rdy[pt_sel]) begin
               state     <= DONE;
               rdy       <= 1'b1;
               key_valid <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_crack_scheduler.sv
// Directed bench for crack_scheduler: global memory model, local-write scoreboard,
// and pulse monitors on the engine control outputs.
module tb_crack_scheduler;

   localparam int NENG = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              en;
   logic              rdy;
   logic [23:0]       key;
   logic              key_valid;
   logic [7:0]        ct_addr;
   logic [7:0]        ct_rddata;
   logic [7:0]        loc_addr;
   logic [7:0]        loc_wrdata;
   logic              loc_wren;
   logic              loc_sel;
   logic [NENG-1:0]   eng_en;
   logic [NENG-1:0]   eng_rdy;
   logic [NENG-1:0]   eng_key_valid;
   logic [24*NENG-1:0] eng_key;
   logic [24*NENG-1:0] eng_base;
   logic [NENG-1:0]   eng_abort;
   logic [NENG-1:0]   eng_pt_en;
   logic [1:0]        pt_sel;

   crack_scheduler #(.NENG(NENG)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .key_valid(key_valid),
      .ct_addr(ct_addr), .ct_rddata(ct_rddata), .loc_addr(loc_addr),
      .loc_wrdata(loc_wrdata), .loc_wren(loc_wren), .loc_sel(loc_sel),
      .eng_en(eng_en), .eng_rdy(eng_rdy), .eng_key_valid(eng_key_valid),
      .eng_key(eng_key), .eng_base(eng_base), .eng_abort(eng_abort),
      .eng_pt_en(eng_pt_en), .pt_sel(pt_sel)
   );

   always #5 clk = ~clk;

   // Global memory: data for an address appears two clocks later.
   logic [7:0] mem [256];
   logic [7:0] rd1;
   always @(posedge clk) begin
      rd1       <= mem[ct_addr];
      ct_rddata <= rd1;
   end

   int checks = 0, failures = 0;
   int wr_cnt = 0, z_cnt = 0, en_cnt = 0, ab_cnt = 0, pt_cnt = 0;
   logic [7:0] wr_last;
   logic [NENG-1:0] en_last, ab_last, pt_last;
   logic [15:0] wq [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one cycle and monitor pulses / local writes away from the edge.
   task automatic step();
      logic [15:0] e;
      @(posedge clk);
      #1;
      if (loc_wren === 1'b1) begin
         wr_cnt++;
         wr_last = loc_addr;
         if (loc_addr == 8'd0) z_cnt++;
         if (wq.size() == 0) chk("wr_extra", wq.size(), 1);
         else begin
            e = wq.pop_front();
            chk("wr", {loc_addr, loc_wrdata}, e);
            chk("wr_sel", loc_sel, 1);
         end
      end
      if (|eng_en)    begin en_cnt++; en_last = eng_en;    end
      if (|eng_abort) begin ab_cnt++; ab_last = eng_abort; end
      if (|eng_pt_en) begin
         pt_cnt++;
         pt_last = eng_pt_en;
         chk("pt_onehot", 32'($onehot(eng_pt_en)), 1);
      end
   endtask

   task automatic fill(input int len);
      mem[0] = 8'(len);
      wq.push_back({8'h00, 8'(len)});
      for (int i = 1; i <= len; i++) begin
         mem[i] = 8'($urandom);
         wq.push_back({8'(i), mem[i]});
      end
   endtask

   task automatic go();
      en = 1'b1;
      step();
      en = 1'b0;
      chk("rdy_drop", rdy, 0);
   endtask

   task automatic wait_en(input int target, input int n);
      int c = 0;
      while (en_cnt < target && c < n) begin step(); c++; end
      chk("eng_en_seen", en_cnt, target);
   endtask

   task automatic wait_rdy(input int n);
      int c = 0;
      while (rdy !== 1'b1 && c < n) begin step(); c++; end
      chk("rdy_timeout", rdy, 1);
   endtask

   // Engines start, go busy, then all report ready without a key.
   task automatic finish_no_win();
      eng_rdy = '0;
      repeat (4) step();
      eng_rdy = '1;
      wait_rdy(6);
      chk("nowin_kv", key_valid, 0);
      chk("nowin_key", key, 0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      rst_n = 1'b0; en = 1'b0; eng_rdy = '0; eng_key_valid = '0;
      eng_key = {24'd7, 24'd2, 24'd5, 24'd9};
      repeat (2) step();

      chk("rst_rdy", rdy, 1);
      chk("rst_kv", key_valid, 0);
      chk("rst_key", key, 0);
      chk("rst_ptsel", pt_sel, 0);
      chk("rst_pulses", {eng_en, eng_abort, eng_pt_en}, 0);
      chk("rst_wren", loc_wren, 0);
      chk("rst_locsel", loc_sel, 1);
      chk("rst_addrs", {ct_addr, loc_addr}, 0);
      rst_n = 1'b1;
      step();
      chk("post_rst_pulses", {eng_en, eng_abort, eng_pt_en}, 0);
      for (int k = 0; k < NENG; k++) chk("base", eng_base[24*k +: 24], k);

      // L=3 copy, en held high, engines not all ready; then engines 1 and 3 win together.
      mem[0] = 8'h03; mem[1] = 8'hAA; mem[2] = 8'hBB; mem[3] = 8'hCC;
      wq.push_back(16'h0003); wq.push_back(16'h01AA);
      wq.push_back(16'h02BB); wq.push_back(16'h03CC);
      eng_rdy = 4'b0111;
      en = 1'b1;
      step();
      chk("rdy_drop", rdy, 0);
      repeat (25) step();
      chk("a_wr_cnt", wr_cnt, 4);
      chk("a_wq_empty", wq.size(), 0);
      chk("a_no_en_yet", en_cnt, 0);
      chk("a_locsel_held", loc_sel, 1);
      eng_rdy = 4'b1111;
      wait_en(1, 6);
      en = 1'b0;
      chk("a_en_val", en_last, 4'b1111);
      chk("a_locsel_rel", loc_sel, 0);
      eng_rdy = '0;
      repeat (3) step();
      eng_key_valid = 4'b1010;
      eng_rdy       = 4'b1010;
      begin
         int c = 0;
         while (pt_cnt < 1 && c < 12) begin step(); c++; end
      end
      chk("a_pt_seen", pt_cnt, 1);
      chk("a_pt_val", pt_last, 4'b0010);
      chk("a_ab_cnt", ab_cnt, 1);
      chk("a_ab_val", ab_last, 4'b1101);
      chk("a_key", key, 24'h000005);
      chk("a_ptsel", pt_sel, 1);
      eng_key_valid = '0;
      eng_rdy       = '0;
      repeat (6) step();
      chk("a_ptwait", rdy, 0);
      eng_rdy = 4'b0010;
      wait_rdy(5);
      chk("a_kv", key_valid, 1);
      chk("a_key_done", key, 24'h000005);
      chk("a_ptsel_hold", pt_sel, 1);
      chk("a_pt_once", pt_cnt, 1);

      // L=0: only byte 0 is written; en in DONE clears the result; no winner.
      fill(0);
      eng_rdy = '1;
      go();
      chk("b_kv_clr", key_valid, 0);
      chk("b_key_clr", key, 0);
      chk("b_ptsel_clr", pt_sel, 0);
      wait_en(2, 15);
      chk("b_wr_cnt", wr_cnt, 5);
      finish_no_win();
      chk("b_no_pt", pt_cnt, 1);
      chk("b_no_abort", ab_cnt, 1);

      // L=255: 256 writes ending at FF, address 00 written only once.
      fill(255);
      eng_rdy = '0;
      go();
      begin
         int c = 0;
         while (wr_cnt < 261 && c < 1000) begin step(); c++; end
      end
      repeat (5) step();
      chk("c_wr_cnt", wr_cnt, 261);
      chk("c_last", wr_last, 8'hFF);
      chk("c_zero_once", z_cnt, 3);
      chk("c_wq_empty", wq.size(), 0);
      chk("c_no_en", en_cnt, 2);
      eng_rdy = '1;
      wait_en(3, 6);
      finish_no_win();

      // Reset mid-COPY, then a fresh L=2 run.
      fill(10);
      eng_rdy = '0;
      go();
      repeat (12) step();
      rst_n = 1'b0;
      #1;
      chk("d_rst_rdy", rdy, 1);
      chk("d_rst_wren", loc_wren, 0);
      chk("d_rst_locsel", loc_sel, 1);
      chk("d_rst_addrs", {ct_addr, loc_addr}, 0);
      chk("d_rst_pulses", {eng_en, eng_abort, eng_pt_en}, 0);
      wq.delete();
      step();
      rst_n = 1'b1;
      step();
      chk("d_idle", rdy, 1);
      fill(2);
      eng_rdy = '1;
      go();
      wait_en(4, 20);
      finish_no_win();
      chk("d_wq_empty", wq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
